// File: rtl/perf_pkg.sv
// perf_pkg: shared definitions for the performance monitor.
//   CNT_W_DEF / OUT_W_DEF : default counter and CPI result widths
//   retire_class_e        : class code carried with a retiring instruction
//   div_state_e           : states of the CPI division sequencer
package perf_pkg;

  localparam int CNT_W_DEF = 19;
  localparam int OUT_W_DEF = 16;

  // Code 3 is reserved and is treated like CLS_OTHER.
  typedef enum logic [1:0] {
    CLS_OTHER = 2'd0,
    CLS_ARITH = 2'd1,
    CLS_MEM   = 2'd2
  } retire_class_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/perf_divider.sv
// perf_divider: sequential restoring divider, one quotient bit per cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   start_i       : load dividend/divisor and begin (ignored while busy)
//   abort_i       : synchronous abort of a division in progress
//   dividend_i    : CNT_W-bit dividend
//   divisor_i     : CNT_W-bit divisor (caller guarantees nonzero)
//   busy_o        : division in progress
//   done_o        : final iteration this cycle; quotient_o is final from the next cycle
//   quotient_o    : CNT_W-bit quotient
module perf_divider
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] quotient_o
);

  localparam int CW = $clog2(CNT_W + 1);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [CNT_W:0]   rem_q, rem_sh, rem_d;
  logic [CNT_W-1:0] quo_q, quo_d, dsr_q;

  logic load;
  assign load = start_i && !busy_q && !abort_i;

  // Iteration control: CNT_W busy cycles after a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(CNT_W);
    end else if (busy_q) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  // Restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor only when it fits.
  always_comb begin
    rem_sh = {rem_q[CNT_W-1:0], quo_q[CNT_W-1]};
    rem_d  = rem_sh;
    quo_d  = {quo_q[CNT_W-2:0], 1'b0};
    if (rem_sh >= {1'b0, dsr_q}) begin
      rem_d = rem_sh - {1'b0, dsr_q};
      quo_d = {quo_q[CNT_W-2:0], 1'b1};
    end
  end

  // Datapath registers; quo_q starts as the dividend and fills with quotient bits.
  always_ff @(posedge clk) begin
    if (load) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dsr_q <= divisor_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == CW'(1));
  assign quotient_o = quo_q;

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: execution statistics beside the writeback stage.
//   clk, rst          : clock, asynchronous active-high reset
//   stall             : pipeline stalled this cycle
//   retire            : one instruction retires this cycle
//   retire_class      : class of retiring instruction (0 other, 1 arith, 2 mem, 3 other)
//   freeze            : level; counters hold while high, one final CPI is computed
//   clear             : synchronous clear of counters, results and divider
//   *_count           : saturating event counters
//   cpi               : last cycle_count / instruction_count, saturated to OUT_W
//   cpi_valid         : a division has completed since reset or clear
//   final_valid       : the post-freeze division has completed (held while frozen)
module perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             retire,
  input  logic [1:0]       retire_class,
  input  logic             freeze,
  input  logic             clear,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] aritmetric_count,
  output logic [CNT_W-1:0] memory_count,
  output logic [CNT_W-1:0] instruction_count,
  output logic [OUT_W-1:0] cpi,
  output logic             cpi_valid,
  output logic             final_valid
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] sat_cpi(input logic [CNT_W-1:0] q);
    if ((q >> OUT_W) != '0) return '1;
    return q[OUT_W-1:0];
  endfunction

  logic [CNT_W-1:0] cyc_q, stl_q, ari_q, mem_q, ins_q;
  logic [OUT_W-1:0] cpi_q;
  logic             cpi_valid_q, final_valid_q, final_run_q;
  div_state_e       state_q;

  logic             div_go, div_busy, div_done;
  logic [CNT_W-1:0] div_quo;

  // Event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      cyc_q <= '0;
      stl_q <= '0;
      ari_q <= '0;
      mem_q <= '0;
      ins_q <= '0;
    end else if (!freeze) begin
      cyc_q <= sat_inc(cyc_q, 1'b1);
      stl_q <= sat_inc(stl_q, stall);
      ins_q <= sat_inc(ins_q, retire);
      ari_q <= sat_inc(ari_q, retire && (retire_class == CLS_ARITH));
      mem_q <= sat_inc(mem_q, retire && (retire_class == CLS_MEM));
    end
  end

  // Once the frozen result is out, the sequencer parks in IDLE until freeze drops.
  assign div_go = (state_q == DIV_IDLE) && !clear && !div_busy &&
                  (ins_q != '0) && !(freeze && final_valid_q);

  perf_divider #(.CNT_W(CNT_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_go),
    .abort_i    (clear),
    .dividend_i (cyc_q),
    .divisor_i  (ins_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // Division sequencer and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      state_q       <= DIV_IDLE;
      cpi_q         <= '0;
      cpi_valid_q   <= 1'b0;
      final_valid_q <= 1'b0;
      final_run_q   <= 1'b0;
    end else begin
      if (!freeze) final_valid_q <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (div_go) begin
            state_q     <= DIV_RUN;
            // A division launched while frozen sees the final counts.
            final_run_q <= freeze;
          end else if (freeze && !final_valid_q && (ins_q == '0)) begin
            final_valid_q <= 1'b1;
            cpi_q         <= '0;
          end
        end
        DIV_RUN: begin
          if (div_done) state_q <= DIV_DONE;
        end
        DIV_DONE: begin
          cpi_q       <= sat_cpi(div_quo);
          cpi_valid_q <= 1'b1;
          if (final_run_q && freeze) final_valid_q <= 1'b1;
          state_q     <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign cycle_count       = cyc_q;
  assign stall_count       = stl_q;
  assign aritmetric_count  = ari_q;
  assign memory_count      = mem_q;
  assign instruction_count = ins_q;
  assign cpi               = cpi_q;
  assign cpi_valid         = cpi_valid_q;
  assign final_valid       = final_valid_q;

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed bench for perf_monitor. Instance A uses the
// default widths; instance B uses CNT_W=10/OUT_W=4 so counter and quotient
// saturation are reachable in a short run.
module tb_perf_monitor;

  logic clk;
  logic rst;

  logic        stall_a, retire_a, freeze_a, clear_a;
  logic [1:0]  cls_a;
  logic [18:0] cyc_a, stl_a, ari_a, mem_a, ins_a;
  logic [15:0] cpi_a;
  logic        cpiv_a, finv_a;

  logic        stall_b, retire_b, freeze_b, clear_b;
  logic [1:0]  cls_b;
  logic [9:0]  cyc_b, stl_b, ari_b, mem_b, ins_b;
  logic [3:0]  cpi_b;
  logic        cpiv_b, finv_b;

  int nvec = 0;
  int nerr = 0;

  perf_monitor dut_a (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall_a),
    .retire            (retire_a),
    .retire_class      (cls_a),
    .freeze            (freeze_a),
    .clear             (clear_a),
    .cycle_count       (cyc_a),
    .stall_count       (stl_a),
    .aritmetric_count  (ari_a),
    .memory_count      (mem_a),
    .instruction_count (ins_a),
    .cpi               (cpi_a),
    .cpi_valid         (cpiv_a),
    .final_valid       (finv_a)
  );

  perf_monitor #(.CNT_W(10), .OUT_W(4)) dut_b (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall_b),
    .retire            (retire_b),
    .retire_class      (cls_b),
    .freeze            (freeze_b),
    .clear             (clear_b),
    .cycle_count       (cyc_b),
    .stall_count       (stl_b),
    .aritmetric_count  (ari_b),
    .memory_count      (mem_b),
    .instruction_count (ins_b),
    .cpi               (cpi_b),
    .cpi_valid         (cpiv_b),
    .final_valid       (finv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    stall_a = 0; retire_a = 0; freeze_a = 0; clear_a = 0; cls_a = 2'd0;
    stall_b = 0; retire_b = 0; freeze_b = 0; clear_b = 0; cls_b = 2'd0;
    step(2);

    // Reset values
    chk("rst_cycle", 32'(cyc_a), 32'd0);
    chk("rst_cpi", 32'(cpi_a), 32'd0);
    chk("rst_cpi_valid", 32'(cpiv_a), 32'd0);
    chk("rst_final_valid", 32'(finv_a), 32'd0);
    chk("rst_b_cycle", 32'(cyc_b), 32'd0);
    rst = 1'b0;

    // 100 idle cycles
    step(100);
    chk("idle_cycle", 32'(cyc_a), 32'd100);
    chk("idle_stall", 32'(stl_a), 32'd0);
    chk("idle_instr", 32'(ins_a), 32'd0);
    chk("idle_arith", 32'(ari_a), 32'd0);
    chk("idle_mem", 32'(mem_a), 32'd0);
    chk("idle_cpi_valid", 32'(cpiv_a), 32'd0);

    // Retire every cycle, classes alternating 1,2; first CPI after 21 cycles
    clear_a = 1; step(1); clear_a = 0;
    for (int i = 0; i < 40; i++) begin
      retire_a = 1;
      cls_a = (i % 2 == 0) ? 2'd1 : 2'd2;
      step(1);
      if (i == 20) chk("cpi_not_yet", 32'(cpiv_a), 32'd0);
      if (i == 21) begin
        chk("first_cpi", 32'(cpi_a), 32'd1);
        chk("first_cpi_valid", 32'(cpiv_a), 32'd1);
      end
    end
    retire_a = 0; cls_a = 2'd0;
    chk("alt_instr", 32'(ins_a), 32'd40);
    chk("alt_arith", 32'(ari_a), 32'd20);
    chk("alt_mem", 32'(mem_a), 32'd20);
    chk("alt_stall", 32'(stl_a), 32'd0);

    // Clear while a division is running
    clear_a = 1; step(1); clear_a = 0;
    chk("clr_cycle", 32'(cyc_a), 32'd0);
    chk("clr_instr", 32'(ins_a), 32'd0);
    chk("clr_arith", 32'(ari_a), 32'd0);
    chk("clr_mem", 32'(mem_a), 32'd0);
    chk("clr_cpi", 32'(cpi_a), 32'd0);
    chk("clr_cpi_valid", 32'(cpiv_a), 32'd0);
    step(30);
    chk("clr_no_restart", 32'(cpiv_a), 32'd0);
    chk("clr_cycle30", 32'(cyc_a), 32'd30);
    retire_a = 1; step(1); retire_a = 0;
    step(20);
    chk("restart_wait", 32'(cpiv_a), 32'd0);
    step(1);
    chk("restart_cpi", 32'(cpi_a), 32'd31);
    chk("restart_valid", 32'(cpiv_a), 32'd1);

    // Simultaneous stall and retire, then reserved class
    clear_a = 1; step(1); clear_a = 0;
    stall_a = 1; retire_a = 1; cls_a = 2'd0;
    step(10);
    stall_a = 0; cls_a = 2'd3;
    step(5);
    retire_a = 0; cls_a = 2'd0;
    chk("sr_stall", 32'(stl_a), 32'd10);
    chk("sr_instr", 32'(ins_a), 32'd15);
    chk("sr_arith", 32'(ari_a), 32'd0);
    chk("sr_mem", 32'(mem_a), 32'd0);

    // 300 cycles with 100 retires, then freeze
    clear_a = 1; step(1); clear_a = 0;
    for (int i = 0; i < 300; i++) begin
      retire_a = (i % 3 == 0);
      step(1);
    end
    retire_a = 0;
    freeze_a = 1;
    step(16);
    chk("inflight_cpi", 32'(cpi_a), 32'd2);
    chk("inflight_final", 32'(finv_a), 32'd0);
    step(20);
    chk("final_early", 32'(finv_a), 32'd0);
    step(1);
    chk("final_valid", 32'(finv_a), 32'd1);
    chk("final_cpi", 32'(cpi_a), 32'd3);
    step(50);
    chk("frz_cycle", 32'(cyc_a), 32'd300);
    chk("frz_instr", 32'(ins_a), 32'd100);
    chk("frz_final", 32'(finv_a), 32'd1);
    chk("frz_cpi", 32'(cpi_a), 32'd3);
    freeze_a = 0;
    step(1);
    chk("unfrz_final", 32'(finv_a), 32'd0);
    chk("unfrz_cycle", 32'(cyc_a), 32'd301);

    // Freeze with no instructions
    clear_a = 1; step(1); clear_a = 0;
    freeze_a = 1;
    step(1);
    chk("zfrz_final", 32'(finv_a), 32'd1);
    chk("zfrz_cpi", 32'(cpi_a), 32'd0);
    chk("zfrz_cycle", 32'(cyc_a), 32'd0);
    freeze_a = 0;
    step(1);
    chk("zfrz_drop", 32'(finv_a), 32'd0);

    // Counter saturation on the narrow instance
    clear_b = 1; step(1); clear_b = 0;
    stall_b = 1;
    step(1029);
    stall_b = 0;
    chk("sat_stall", 32'(stl_b), 32'h3FF);
    chk("sat_cycle", 32'(cyc_b), 32'h3FF);
    chk("sat_instr", 32'(ins_b), 32'd0);
    chk("sat_arith", 32'(ari_b), 32'd0);
    chk("sat_mem", 32'(mem_b), 32'd0);
    chk("sat_cpiv", 32'(cpiv_b), 32'd0);
    chk("sat_final", 32'(finv_b), 32'd0);

    // Quotient saturation on the narrow instance
    clear_b = 1; step(1); clear_b = 0;
    retire_b = 1; step(1); retire_b = 0;
    step(24);
    chk("q_unsat", 32'(cpi_b), 32'd13);
    step(11);
    chk("q_unsat_hold", 32'(cpi_b), 32'd13);
    step(1);
    chk("q_sat", 32'(cpi_b), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Performance monitor that produces the execution statistics shown by the scalar register file's R28–R31 readout, with R31 as cycles per instruction. It sits beside the pipeline's writeback stage. It counts cycles, stalls, retired instructions and their class. It computes integer cycles-per-instruction with a sequential divider, so there is no combinational divide in the register-file path. It supports freeze and clear so that a program's final statistics remain stable after it finishes.

## Interface
- CNT_W, 19, width of every event counter (matches the register-file count inputs)
- OUT_W, 16, width of the CPI result (matches the register-file data width)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  pipeline stalled this cycle
- retire  in  1  one instruction retires at writeback this cycle
- retire_class  in  2  class of the retiring instruction: 0 other, 1 arithmetic, 2 memory, 3 reserved (counted as other)
- freeze  in  1  level; counters hold while high (driven from the register file's finish)
- clear  in  1  synchronous; zeroes counters and results, aborts any division
- cycle_count, stall_count, aritmetric_count, memory_count, instruction_count  out  CNT_W each  registered counter values
- cpi  out  OUT_W  last completed cycle_count / instruction_count (integer)
- cpi_valid  out  1  high once any division has completed since reset or clear
- final_valid  out  1  high after the post-freeze division completes; stays high while freeze is high

## Operation
- Reset: every output is 0. Divider FSM is IDLE.
- Counters, per cycle when freeze=0 and clear=0:
  - cycle_count +1.
  - stall_count +1 if stall.
  - instruction_count +1 if retire.
  - aritmetric_count +1 if retire and class=1.
  - memory_count +1 if retire and class=2.
- Every counter saturates at all-ones (2^CNT_W−1) and does not wrap.
- Simultaneous stall and retire: both counters increment.
- clear has priority over freeze and over every increment.
- Divider FSM:
  - IDLE → DIV when instruction_count≠0. On entry, snapshot dividend=cycle_count and divisor=instruction_count.
  - DIV performs a restoring shift-subtract of one quotient bit per cycle for exactly CNT_W cycles, then → DONE.
  - DONE writes cpi, sets cpi_valid, then → IDLE.
- If the quotient exceeds 2^OUT_W−1, cpi = all-ones (saturate).
- Freeze handling:
  - On the rising edge of freeze, any division in progress completes normally and its result is written.
  - The FSM then runs exactly one more division on the frozen counts, sets final_valid at its DONE, and remains in IDLE while freeze stays high.
  - If instruction_count=0 at freeze, final_valid sets immediately and cpi is 0.
- Freeze falling: final_valid clears next cycle and normal free-running division resumes.
- clear mid-division: FSM → IDLE next cycle; cpi, cpi_valid and final_valid → 0.

## Timing
- Counters are registered: an event in cycle n is visible on the outputs at n+1.
- Division latency, from IDLE sampling a nonzero divisor to cpi updating: 1 (snapshot) + CNT_W (DIV) + 1 (DONE) = CNT_W+2 cycles, which is 21 for the defaults.
- Free-running back-to-back divisions therefore update cpi every CNT_W+2 cycles.
- cpi, cpi_valid and final_valid change only on a DONE cycle, on clear, or on rst.

## Structure
- perf_pkg contains:
  - CNT_W and OUT_W defaults.
  - the retire-class enum (CLS_OTHER, CLS_ARITH, CLS_MEM).
  - the divider state enum (DIV_IDLE, DIV_RUN, DIV_DONE).
- Sub-module perf_divider is a sequential restoring divider.
  - Ports: start/busy/done handshake, dividend, divisor, quotient.
  - Width is parameterised by CNT_W.
- perf_monitor contains the counters, the freeze sequencing, and the saturation of the quotient to OUT_W.

## Test plan
- Reset then 100 idle cycles → cycle_count=100; all other counters 0; cpi_valid=0.
- retire every cycle for 40 cycles with classes alternating 1,2 → instruction_count=40, aritmetric_count=20, memory_count=20; first cpi=1 at 21 cycles after the first retire is visible.
- Simultaneous stall and retire for 10 cycles → stall_count=10 and instruction_count=10.
- Preload via long run: 300 cycles with 100 retires, then freeze → final_valid rises 21 cycles after any in-flight division ends; cpi=3; counters hold for 50 more cycles.
- Counter saturation: stall held for 2^19+5 cycles → stall_count=0x7FFFF.
- Quotient saturation: 1 retire followed by 100000 cycles → cpi=0xFFFF.
- clear asserted mid-DIV → next cycle all counters 0, cpi=0, cpi_valid=0; division restarts only after the next retire.
